// File: rtl/mdu_pkg.sv
// Shared encodings and widths for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_div_radix2.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with sign correction and divide-by-zero handling folded into the final iteration.
module div_radix2
  import mdu_pkg::*;
#(
  parameter int unsigned Iters = MDU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_i,
  input  logic                 op_signed_i,
  input  logic                 abort_i,
  input  logic [MDU_WIDTH-1:0] dividend_i,
  input  logic [MDU_WIDTH-1:0] divisor_i,
  output logic                 done_o,
  output logic [MDU_WIDTH-1:0] quot_o,
  output logic [MDU_WIDTH-1:0] rem_o
);

  localparam int unsigned W    = MDU_WIDTH;
  localparam int unsigned CntW = $clog2(Iters);
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

  logic [W-1:0]    rem_q, dvd_q, dsr_q, raw_a_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q, neg_quot_q, neg_rem_q, div_zero_q;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      rem_s, diff;
  logic [W-1:0]    rem_n, dvd_n;

  always_comb begin
    a_neg = op_signed_i & dividend_i[W-1];
    b_neg = op_signed_i & divisor_i[W-1];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i : divisor_i;
  end

  // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
  always_comb begin
    rem_s = {rem_q, dvd_q[W-1]};
    diff  = rem_s - {1'b0, dsr_q};
    if (!diff[W]) begin
      rem_n = diff[W-1:0];
      dvd_n = {dvd_q[W-2:0], 1'b1};
    end else begin
      rem_n = rem_s[W-1:0];
      dvd_n = {dvd_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    done_o = run_q && (cnt_q == LastCnt);
    if (div_zero_q) begin
      quot_o = '1;
      rem_o  = raw_a_q;
    end else begin
      quot_o = neg_quot_q ? -dvd_n : dvd_n;
      rem_o  = neg_rem_q ? -rem_n : rem_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      raw_a_q    <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (go_i) begin
      rem_q      <= '0;
      dvd_q      <= a_mag;
      dsr_q      <= b_mag;
      raw_a_q    <= dividend_i;
      cnt_q      <= '0;
      run_q      <= 1'b1;
      neg_quot_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_zero_q <= (divisor_i == '0);
    end else if (run_q) begin
      rem_q <= rem_n;
      dvd_q <= dvd_n;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU engine writing HI/LO; ready and busy are
// registered so the hazard unit never sees a combinational path back from start/stall.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 2,
  parameter int unsigned DIV_ITERS   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mult_div_start,
  input  logic [1:0]           op,
  input  logic [MDU_WIDTH-1:0] src_a,
  input  logic [MDU_WIDTH-1:0] src_b,
  input  logic                 stall_e,
  input  logic                 flush_e,
  output logic                 mult_div_ready,
  output logic                 busy,
  output logic [MDU_WIDTH-1:0] hi,
  output logic [MDU_WIDTH-1:0] lo
);

  localparam int unsigned W = MDU_WIDTH;
  localparam logic [2:0] MulLast = 3'(MULT_CYCLES - 1);

  mdu_state_e   state_q;
  logic         ready_q, busy_q;
  logic [W-1:0] hi_q, lo_q;
  logic [2:0]   mul_cnt_q;
  logic [2*W-1:0] prod_pipe_q [MULT_CYCLES];

  logic           launch, mul_signed;
  logic [2*W-1:0] a_ext, b_ext, product;
  logic           div_done;
  logic [W-1:0]   div_quot, div_rem;

  assign launch     = (state_q == StIdle) && mult_div_start && !flush_e;
  assign mul_signed = ~op[0];

  // Low 64 bits of the 33x33 signed product; zero-extension covers MULTU.
  always_comb begin
    a_ext   = {{W{mul_signed & src_a[W-1]}}, src_a};
    b_ext   = {{W{mul_signed & src_b[W-1]}}, src_b};
    product = a_ext * b_ext;
  end

  // Stage 0 captures the product at launch and then holds, so later operand changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MULT_CYCLES; k++) begin
        prod_pipe_q[k] <= '0;
      end
    end else begin
      if (launch && !op[1]) begin
        prod_pipe_q[0] <= product;
      end
      for (int k = 1; k < MULT_CYCLES; k++) begin
        prod_pipe_q[k] <= prod_pipe_q[k-1];
      end
    end
  end

  div_radix2 #(
    .Iters(DIV_ITERS)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .go_i       (launch & op[1]),
    .op_signed_i(~op[0]),
    .abort_i    (flush_e),
    .dividend_i (src_a),
    .divisor_i  (src_b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_cnt_q <= '0;
    end else if (flush_e) begin
      // Abort without touching HI/LO: they keep the last committed result.
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      mul_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mult_div_start) begin
            state_q   <= op[1] ? StDiv : StMul;
            busy_q    <= 1'b1;
            mul_cnt_q <= '0;
          end
        end
        StMul: begin
          if (mul_cnt_q == MulLast) begin
            {hi_q, lo_q} <= prod_pipe_q[MULT_CYCLES-1];
            state_q      <= StDone;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            mul_cnt_q    <= '0;
          end else begin
            mul_cnt_q <= mul_cnt_q + 1'b1;
          end
        end
        StDiv: begin
          if (div_done) begin
            lo_q    <= div_quot;
            hi_q    <= div_rem;
            state_q <= StDone;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        StDone: begin
          if (!stall_e) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mult_div_ready = ready_q;
  assign busy           = busy_q;
  assign hi             = hi_q;
  assign lo             = lo_q;

endmodule
